// File: rtl/opto_period_meter_pkg.sv
// opto_period_meter_pkg
// Shared definitions for the opto period meter: FSM state encoding, default
// parameter values and a small saturating-increment helper for the good-count.
package opto_period_meter_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StArmed  = 3'd1,
        StTrack  = 3'd2,
        StLocked = 3'd3,
        StStall  = 3'd4
    } meter_state_e;

    localparam int unsigned DEFAULT_CNT_W        = 32;
    localparam int unsigned DEFAULT_STALL_CYCLES = 50_000_000;
    localparam int unsigned DEFAULT_TOL_SHIFT    = 5;
    localparam int unsigned DEFAULT_LOCK_CNT     = 8;

    // Good-count width; LOCK_CNT must not exceed 2**GOOD_W - 1.
    localparam int unsigned GOOD_W = 4;

    function automatic logic [GOOD_W-1:0] good_inc(input logic [GOOD_W-1:0] g);
        return (g == '1) ? g : g + GOOD_W'(1);
    endfunction

endpackage

// File: rtl/opto_period_meter_if.sv
// opto_period_meter_if
// Measurement bus produced by the period meter and consumed by rotate control
// and the angle/encoder logic.
//   index_pulse  : one-cycle pulse per detected rising edge of the opto signal
//   period       : last measured period in clocks, held between updates
//   period_valid : one-cycle strobe, period updated this cycle
//   locked       : speed within tolerance for LOCK_CNT consecutive periods
//   stall        : no rising edge for STALL_CYCLES clocks
// Modports: master (meter drives), slave (consumers read).
interface opto_period_meter_if #(
    parameter int unsigned CNT_W = 32
) ();

    logic             index_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             stall;

    modport master (
        output index_pulse,
        output period,
        output period_valid,
        output locked,
        output stall
    );

    modport slave (
        input index_pulse,
        input period,
        input period_valid,
        input locked,
        input stall
    );

endinterface

// File: rtl/opto_period_meter_tol_check.sv
// opto_period_meter_tol_check
// Combinational speed tolerance test: |period - target| <= (target >> TOL_SHIFT).
// A zero target is never in tolerance. Also used by the encoder sanity check.
//   i_period  : measured period in clocks
//   i_target  : expected period in clocks
//   o_in_tol  : 1 when the period is within tolerance of the target
module opto_period_meter_tol_check #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned TOL_SHIFT = 5
) (
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_target,
    output logic             o_in_tol
);

    logic [CNT_W:0] diff;
    logic [CNT_W:0] tol;

    always_comb begin
        // One extra bit keeps the magnitude exact for any operand pair.
        if (i_period >= i_target) begin
            diff = {1'b0, i_period} - {1'b0, i_target};
        end else begin
            diff = {1'b0, i_target} - {1'b0, i_period};
        end
        tol      = {1'b0, i_target >> TOL_SHIFT};
        o_in_tol = (i_target != '0) && (diff <= tol);
    end

endmodule

// File: rtl/opto_period_meter.sv
// opto_period_meter
// Measures the scanning motor rotation period from the debounced opto switch.
// Emits an index pulse per rising edge, the period between consecutive rises,
// a speed-locked flag against a programmed target and a stall flag.
//   i_clk           : system clock
//   i_rst_n         : asynchronous active-low reset
//   i_opto_switch   : debounced opto signal, synchronous to i_clk
//   i_target_period : expected period in clocks, quasi-static
//   meas            : measurement bus (master side), see opto_period_meter_if
module opto_period_meter
    import opto_period_meter_pkg::*;
#(
    parameter int unsigned CNT_W        = DEFAULT_CNT_W,
    parameter int unsigned STALL_CYCLES = DEFAULT_STALL_CYCLES,
    parameter int unsigned TOL_SHIFT    = DEFAULT_TOL_SHIFT,
    parameter int unsigned LOCK_CNT     = DEFAULT_LOCK_CNT
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_opto_switch,
    input  logic [CNT_W-1:0]            i_target_period,
    opto_period_meter_if.master         meas
);

    localparam logic [CNT_W-1:0]  STALL_C = CNT_W'(STALL_CYCLES);
    localparam logic [GOOD_W-1:0] LOCK_C  = GOOD_W'(LOCK_CNT);

    logic              r_prev;
    logic [CNT_W-1:0]  r_cnt;
    meter_state_e      r_state;
    logic [GOOD_W-1:0] r_good;

    logic              rise;
    logic              cnt_at_stall;
    logic              in_tol;
    logic [GOOD_W-1:0] good_next;
    logic              lock_reached;

    // r_prev resets high so a signal held high through reset is not an edge.
    assign rise         = i_opto_switch & ~r_prev;
    assign cnt_at_stall = (r_cnt == STALL_C);
    assign good_next    = in_tol ? good_inc(r_good) : '0;
    assign lock_reached = (good_next >= LOCK_C);

    // r_cnt is the tolerance-check operand: at a rise it equals the period.
    opto_period_meter_tol_check #(
        .CNT_W     (CNT_W),
        .TOL_SHIFT (TOL_SHIFT)
    ) u_tol_check (
        .i_period (r_cnt),
        .i_target (i_target_period),
        .o_in_tol (in_tol)
    );

    // Period counter: loads 1 on a rise so that its value at the next rise is
    // the cycle distance; saturates at STALL_CYCLES.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b1;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_opto_switch;
            if (rise) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt < STALL_C) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Measurement FSM with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state           <= StIdle;
            r_good            <= '0;
            meas.index_pulse  <= 1'b0;
            meas.period       <= '0;
            meas.period_valid <= 1'b0;
            meas.locked       <= 1'b0;
            meas.stall        <= 1'b0;
        end else begin
            meas.index_pulse  <= rise;
            meas.period_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_good <= '0;
                    if (rise) begin
                        r_state <= StArmed;
                    end
                end
                StArmed, StTrack, StLocked: begin
                    // A rise wins over a coincident stall threshold.
                    if (rise) begin
                        meas.period       <= r_cnt;
                        meas.period_valid <= 1'b1;
                        r_good            <= good_next;
                        if (((r_state == StTrack) && lock_reached) ||
                            ((r_state == StLocked) && in_tol)) begin
                            r_state     <= StLocked;
                            meas.locked <= 1'b1;
                        end else begin
                            r_state     <= StTrack;
                            meas.locked <= 1'b0;
                        end
                    end else if (cnt_at_stall) begin
                        r_state     <= StStall;
                        r_good      <= '0;
                        meas.locked <= 1'b0;
                        meas.stall  <= 1'b1;
                    end
                end
                StStall: begin
                    // The period spanning the stall is meaningless; re-arm.
                    if (rise) begin
                        r_state    <= StArmed;
                        meas.stall <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_good      <= '0;
                    meas.locked <= 1'b0;
                    meas.stall  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opto_period_meter.sv
// tb_opto_period_meter
// Self-checking bench for opto_period_meter. Rises are placed a chosen number
// of clock edges apart; a behavioural model predicts each outcome from the
// gap sequence alone.
module tb_opto_period_meter;

    localparam int unsigned CNT_W     = 32;
    localparam int unsigned STALL     = 2000;
    localparam int unsigned TOL_SHIFT = 5;
    localparam int unsigned LOCK_CNT  = 8;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_opto_switch;
    logic [CNT_W-1:0] i_target_period;

    opto_period_meter_if #(.CNT_W(CNT_W)) meas ();

    opto_period_meter #(
        .CNT_W        (CNT_W),
        .STALL_CYCLES (STALL),
        .TOL_SHIFT    (TOL_SHIFT),
        .LOCK_CNT     (LOCK_CNT)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_opto_switch   (i_opto_switch),
        .i_target_period (i_target_period),
        .meas            (meas)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a period is produced only when a reference rise exists;
    // lock means the current run of in-tolerance periods is at least LOCK_CNT.
    bit          m_armed  = 1'b0;
    int          m_run    = 0;
    logic [31:0] m_period = '0;
    bit          e_vld;
    int          e_stall_at;

    // Observations from the most recent drive_rise.
    logic        r_idx, r_vld, r_lck, r_stl, r_stl_lck;
    logic [31:0] r_per, r_stl_per;
    int          r_stall_at, r_spur;

    function automatic bit in_tol(input longint p, input longint t);
        longint d;
        if (t == 0) return 1'b0;
        d = (p > t) ? p - t : t - p;
        return d <= (t >> TOL_SHIFT);
    endfunction

    function automatic bit m_locked();
        return m_run >= LOCK_CNT;
    endfunction

    task automatic model_reset();
        m_armed  = 1'b0;
        m_run    = 0;
        m_period = '0;
    endtask

    task automatic model_rise(input int gap);
        e_vld      = 1'b0;
        e_stall_at = -1;
        if (m_armed && gap > STALL) begin
            e_stall_at = STALL;
            m_armed    = 1'b0;
            m_run      = 0;
        end
        if (!m_armed) begin
            m_armed = 1'b1;
            m_run   = 0;
        end else begin
            e_vld    = 1'b1;
            m_period = 32'(gap);
            m_run    = in_tol(gap, i_target_period) ? m_run + 1 : 0;
        end
    endtask

    // Called at a negedge just after the previous rise edge; places the next
    // rise exactly gap posedges later and samples at the following negedge.
    task automatic drive_rise(input int gap);
        i_opto_switch = 1'b0;
        r_stall_at    = -1;
        r_spur        = 0;
        r_stl_lck     = 1'b0;
        r_stl_per     = '0;
        for (int k = 1; k < gap; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (meas.index_pulse !== 1'b0 || meas.period_valid !== 1'b0) r_spur++;
            if (meas.stall === 1'b1 && r_stall_at < 0) begin
                r_stall_at = k;
                r_stl_lck  = meas.locked;
                r_stl_per  = meas.period;
            end
        end
        i_opto_switch = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        r_idx = meas.index_pulse;
        r_vld = meas.period_valid;
        r_per = meas.period;
        r_lck = meas.locked;
        r_stl = meas.stall;
    endtask

    task automatic test_reset();
        int pulses = 0;
        i_rst_n         = 1'b0;
        i_opto_switch   = 1'b1;
        i_target_period = 32'd1000;
        repeat (3) @(negedge i_clk);
        n_checks++; if (meas.index_pulse !== 1'b0) $display("FAIL reset index_pulse got %0b want 0", meas.index_pulse); else n_pass++;
        n_checks++; if (meas.period !== 32'd0) $display("FAIL reset period got %0d want 0", meas.period); else n_pass++;
        n_checks++; if (meas.period_valid !== 1'b0) $display("FAIL reset period_valid got %0b want 0", meas.period_valid); else n_pass++;
        n_checks++; if (meas.locked !== 1'b0) $display("FAIL reset locked got %0b want 0", meas.locked); else n_pass++;
        n_checks++; if (meas.stall !== 1'b0) $display("FAIL reset stall got %0b want 0", meas.stall); else n_pass++;
        i_rst_n = 1'b1;
        model_reset();
        repeat (6) begin
            @(negedge i_clk);
            if (meas.index_pulse !== 1'b0) pulses++;
        end
        n_checks++; if (pulses != 0) $display("FAIL reset held_high_pulses got %0d want 0", pulses); else n_pass++;
    endtask

    task automatic test_nominal_lock();
        i_target_period = 32'd1000;
        drive_rise(1000);
        model_rise(1000);
        n_checks++; if (r_idx !== 1'b1) $display("FAIL nominal first_index got %0b want 1", r_idx); else n_pass++;
        n_checks++; if (r_vld !== 1'b0) $display("FAIL nominal first_valid got %0b want 0", r_vld); else n_pass++;
        for (int i = 2; i <= 9; i++) begin
            drive_rise(1000);
            model_rise(1000);
            n_checks++; if (r_vld !== e_vld) $display("FAIL nominal valid rise %0d got %0b want %0b", i, r_vld, e_vld); else n_pass++;
            n_checks++; if (r_per !== m_period) $display("FAIL nominal period rise %0d got %0d want %0d", i, r_per, m_period); else n_pass++;
            n_checks++; if (r_lck !== m_locked()) $display("FAIL nominal locked rise %0d got %0b want %0b", i, r_lck, m_locked()); else n_pass++;
        end
        n_checks++; if (r_lck !== 1'b1) $display("FAIL nominal lock_after_9th got %0b want 1", r_lck); else n_pass++;
    endtask

    task automatic test_tol_boundary();
        int gaps [10] = '{1031, 1032, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
        for (int i = 0; i < 10; i++) begin
            drive_rise(gaps[i]);
            model_rise(gaps[i]);
            n_checks++; if (r_per !== m_period) $display("FAIL boundary period step %0d got %0d want %0d", i, r_per, m_period); else n_pass++;
            n_checks++; if (r_lck !== m_locked()) $display("FAIL boundary locked step %0d got %0b want %0b", i, r_lck, m_locked()); else n_pass++;
        end
    endtask

    task automatic test_stall();
        int gap = STALL + 500 + int'($urandom_range(0, 300));
        drive_rise(gap);
        model_rise(gap);
        n_checks++; if (r_stall_at != e_stall_at) $display("FAIL stall onset got %0d want %0d", r_stall_at, e_stall_at); else n_pass++;
        n_checks++; if (r_stl_lck !== 1'b0) $display("FAIL stall locked got %0b want 0", r_stl_lck); else n_pass++;
        n_checks++; if (r_stl_per !== m_period) $display("FAIL stall period_held got %0d want %0d", r_stl_per, m_period); else n_pass++;
        n_checks++; if (r_vld !== 1'b0) $display("FAIL stall first_rise_valid got %0b want 0", r_vld); else n_pass++;
        n_checks++; if (r_stl !== 1'b0) $display("FAIL stall clear got %0b want 0", r_stl); else n_pass++;
        drive_rise(1000);
        model_rise(1000);
        n_checks++; if (r_vld !== 1'b1) $display("FAIL stall second_rise_valid got %0b want 1", r_vld); else n_pass++;
        n_checks++; if (r_per !== m_period) $display("FAIL stall second_rise_period got %0d want %0d", r_per, m_period); else n_pass++;
    endtask

    task automatic test_stall_race();
        drive_rise(STALL);
        model_rise(STALL);
        n_checks++; if (r_vld !== 1'b1) $display("FAIL race valid got %0b want 1", r_vld); else n_pass++;
        n_checks++; if (r_per !== 32'd2000) $display("FAIL race period got %0d want 2000", r_per); else n_pass++;
        n_checks++; if (r_stall_at != -1 || r_stl !== 1'b0) $display("FAIL race stall got onset %0d flag %0b want none", r_stall_at, r_stl); else n_pass++;
    endtask

    task automatic test_random();
        int gap, tol, sel;
        i_target_period = 32'($urandom_range(100, 400));
        tol = int'(i_target_period >> TOL_SHIFT);
        for (int i = 0; i < 50; i++) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0) gap = STALL + int'($urandom_range(1, 100));
            else if (sel <= 2) gap = int'(i_target_period) + tol + int'($urandom_range(1, 40));
            else if (sel <= 4) gap = int'(i_target_period) - tol - int'($urandom_range(1, 40));
            else if (sel <= 10) gap = int'(i_target_period) + int'($urandom_range(0, tol));
            else gap = int'(i_target_period) - int'($urandom_range(0, tol));
            drive_rise(gap);
            model_rise(gap);
            n_checks++; if (r_idx !== 1'b1) $display("FAIL random index step %0d gap %0d got %0b want 1", i, gap, r_idx); else n_pass++;
            n_checks++; if (r_vld !== e_vld) $display("FAIL random valid step %0d gap %0d got %0b want %0b", i, gap, r_vld, e_vld); else n_pass++;
            n_checks++; if (r_per !== m_period) $display("FAIL random period step %0d gap %0d got %0d want %0d", i, gap, r_per, m_period); else n_pass++;
            n_checks++; if (r_lck !== m_locked()) $display("FAIL random locked step %0d gap %0d got %0b want %0b", i, gap, r_lck, m_locked()); else n_pass++;
            n_checks++; if (r_stall_at != e_stall_at) $display("FAIL random stall_onset step %0d gap %0d got %0d want %0d", i, gap, r_stall_at, e_stall_at); else n_pass++;
            n_checks++; if (r_spur != 0) $display("FAIL random spurious step %0d gap %0d got %0d want 0", i, gap, r_spur); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int gap = int'(i_target_period);
        for (int i = 0; i < 9; i++) begin
            drive_rise(gap);
            model_rise(gap);
        end
        n_checks++; if (r_lck !== m_locked()) $display("FAIL reset_mid pre_locked got %0b want %0b", r_lck, m_locked()); else n_pass++;
        i_opto_switch = 1'b0;
        repeat (137) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++; if (meas.period !== 32'd0) $display("FAIL reset_mid period got %0d want 0", meas.period); else n_pass++;
        n_checks++; if (meas.locked !== 1'b0) $display("FAIL reset_mid locked got %0b want 0", meas.locked); else n_pass++;
        n_checks++; if (meas.index_pulse !== 1'b0 || meas.period_valid !== 1'b0 || meas.stall !== 1'b0)
            $display("FAIL reset_mid strobes got idx %0b vld %0b stall %0b want 0", meas.index_pulse, meas.period_valid, meas.stall); else n_pass++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        drive_rise(gap);
        model_rise(gap);
        n_checks++; if (r_idx !== 1'b1 || r_vld !== 1'b0) $display("FAIL reset_mid first_rise got idx %0b vld %0b want idx 1 vld 0", r_idx, r_vld); else n_pass++;
        drive_rise(gap);
        model_rise(gap);
        n_checks++; if (r_vld !== 1'b1) $display("FAIL reset_mid second_rise_valid got %0b want 1", r_vld); else n_pass++;
        n_checks++; if (r_per !== m_period) $display("FAIL reset_mid second_rise_period got %0d want %0d", r_per, m_period); else n_pass++;
    endtask

    task automatic test_zero_target();
        int locks = 0;
        int valids = 0;
        i_target_period = '0;
        for (int i = 0; i < 10; i++) begin
            drive_rise(1000);
            model_rise(1000);
            if (r_lck !== 1'b0) locks++;
            if (r_vld === 1'b1) valids++;
        end
        n_checks++; if (locks != 0) $display("FAIL zero_target locked_rises got %0d want 0", locks); else n_pass++;
        n_checks++; if (valids != 10) $display("FAIL zero_target valid_rises got %0d want 10", valids); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal_lock();
        test_tol_boundary();
        test_stall();
        test_stall_race();
        test_random();
        test_reset_mid();
        test_zero_target();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0d of %0d checks", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
